// File: rtl/reg_rename_stage.sv
// ---------------------------------------------------------------------------
// reg_rename_stage
//
// Purpose:
//   Register rename stage. Takes one decoded instruction per cycle and maps its
//   architectural rs1/rs2/rd (x0..x31) to physical register numbers through a
//   speculative map table. It is the sole consumer of the free list pop port
//   and the sole producer of the free list push port. A committed map table
//   follows retirement. When a retiring instruction supersedes a mapping, the
//   old physical register goes back to the free list. On flush, the
//   speculative map is restored from the committed map.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   in_valid / in_ready          decoded instruction handshake
//   in_rs1, in_rs2, in_rd        architectural register numbers
//   in_rd_write                  instruction writes rd
//   out_valid / out_ready        renamed instruction handshake (registered)
//   out_rs1_phys, out_rs2_phys   physical sources
//   out_rd_phys                  newly allocated destination (0 if none)
//   out_old_rd_phys              previous speculative mapping of rd (0 if none)
//   out_rd_write                 destination allocated
//   take_next_free               free list pop (combinational, same cycle)
//   free_reg_num                 free list head value
//   free_list_empty              free list has no entries
//   reg_freed, freed_reg_num     free list push (registered, 1-cycle pulse)
//   commit_valid, commit_rd,
//   commit_rd_phys               retirement update of the committed map
//   flush                        squash speculative state
// ---------------------------------------------------------------------------
module reg_rename_stage #(
  parameter int REG_FILE_ADDR_WIDTH = 7
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4:0]                     in_rs1,
  input  logic [4:0]                     in_rs2,
  input  logic [4:0]                     in_rd,
  input  logic                           in_rd_write,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [REG_FILE_ADDR_WIDTH-1:0] out_rs1_phys,
  output logic [REG_FILE_ADDR_WIDTH-1:0] out_rs2_phys,
  output logic [REG_FILE_ADDR_WIDTH-1:0] out_rd_phys,
  output logic [REG_FILE_ADDR_WIDTH-1:0] out_old_rd_phys,
  output logic                           out_rd_write,
  output logic                           take_next_free,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] free_reg_num,
  input  logic                           free_list_empty,
  output logic                           reg_freed,
  output logic [REG_FILE_ADDR_WIDTH-1:0] freed_reg_num,
  input  logic                           commit_valid,
  input  logic [4:0]                     commit_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] commit_rd_phys,
  input  logic                           flush
);

  localparam int W = REG_FILE_ADDR_WIDTH;

  // Map tables. Both need a reset value, so they are built from flops.
  logic [W-1:0] spec_map_q   [32];
  logic [W-1:0] spec_map_d   [32];
  logic [W-1:0] commit_map_q [32];
  logic [W-1:0] commit_map_d [32];

  // Output register
  logic         out_valid_q,       out_valid_d;
  logic [W-1:0] out_rs1_phys_q,    out_rs1_phys_d;
  logic [W-1:0] out_rs2_phys_q,    out_rs2_phys_d;
  logic [W-1:0] out_rd_phys_q,     out_rd_phys_d;
  logic [W-1:0] out_old_rd_phys_q, out_old_rd_phys_d;
  logic         out_rd_write_q,    out_rd_write_d;

  // Free list return port
  logic         reg_freed_q,       reg_freed_d;
  logic [W-1:0] freed_reg_num_q,   freed_reg_num_d;

  logic         needs_alloc;
  logic         accept;
  logic         commit_en;
  logic [W-1:0] rs1_lookup;
  logic [W-1:0] rs2_lookup;

  // x0 is never renamed. It must still read phys 0, whatever the map holds.
  assign needs_alloc = in_rd_write && (in_rd != 5'd0);
  assign commit_en   = commit_valid && (commit_rd != 5'd0);
  assign rs1_lookup  = (in_rs1 == 5'd0) ? '0 : spec_map_q[in_rs1];
  assign rs2_lookup  = (in_rs2 == 5'd0) ? '0 : spec_map_q[in_rs2];

  // The output register can take a new instruction when it is empty or is
  // draining this cycle. A destination write also needs a free register.
  assign in_ready       = !flush && (!out_valid_q || out_ready)
                          && (!needs_alloc || !free_list_empty);
  assign accept         = in_valid && in_ready;
  assign take_next_free = accept && needs_alloc;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      commit_map_d[i] = commit_map_q[i];
    end
    if (commit_en) begin
      commit_map_d[commit_rd] = commit_rd_phys;
    end

    // The flush copy takes this cycle's commit into account, so a commit in
    // the same cycle as a flush is not lost.
    for (int i = 0; i < 32; i++) begin
      spec_map_d[i] = flush ? commit_map_d[i] : spec_map_q[i];
    end
    if (!flush && take_next_free) begin
      spec_map_d[in_rd] = free_reg_num;
    end

    reg_freed_d     = commit_en;
    freed_reg_num_d = commit_en ? commit_map_q[commit_rd] : '0;

    out_valid_d       = out_valid_q;
    out_rs1_phys_d    = out_rs1_phys_q;
    out_rs2_phys_d    = out_rs2_phys_q;
    out_rd_phys_d     = out_rd_phys_q;
    out_old_rd_phys_d = out_old_rd_phys_q;
    out_rd_write_d    = out_rd_write_q;
    if (accept) begin
      // Sources come from the map before this cycle's update, so rs == rd
      // sees the previous producer.
      out_valid_d       = 1'b1;
      out_rs1_phys_d    = rs1_lookup;
      out_rs2_phys_d    = rs2_lookup;
      out_rd_phys_d     = needs_alloc ? free_reg_num : '0;
      out_old_rd_phys_d = needs_alloc ? spec_map_q[in_rd] : '0;
      out_rd_write_d    = needs_alloc;
    end else if (out_ready || flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_map_q[i]   <= W'(i);
        commit_map_q[i] <= W'(i);
      end
      out_valid_q       <= 1'b0;
      out_rs1_phys_q    <= '0;
      out_rs2_phys_q    <= '0;
      out_rd_phys_q     <= '0;
      out_old_rd_phys_q <= '0;
      out_rd_write_q    <= 1'b0;
      reg_freed_q       <= 1'b0;
      freed_reg_num_q   <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        spec_map_q[i]   <= spec_map_d[i];
        commit_map_q[i] <= commit_map_d[i];
      end
      out_valid_q       <= out_valid_d;
      out_rs1_phys_q    <= out_rs1_phys_d;
      out_rs2_phys_q    <= out_rs2_phys_d;
      out_rd_phys_q     <= out_rd_phys_d;
      out_old_rd_phys_q <= out_old_rd_phys_d;
      out_rd_write_q    <= out_rd_write_d;
      reg_freed_q       <= reg_freed_d;
      freed_reg_num_q   <= freed_reg_num_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_rs1_phys    = out_rs1_phys_q;
  assign out_rs2_phys    = out_rs2_phys_q;
  assign out_rd_phys     = out_rd_phys_q;
  assign out_old_rd_phys = out_old_rd_phys_q;
  assign out_rd_write    = out_rd_write_q;
  assign reg_freed       = reg_freed_q;
  assign freed_reg_num   = freed_reg_num_q;

endmodule

// File: tb/tb_reg_rename_stage.sv
// ---------------------------------------------------------------------------
// tb_reg_rename_stage
//
// Scoreboard bench for reg_rename_stage. The stimulus process drives the
// inputs one cycle at a time. A reference model of the two map tables decides
// what the DUT must do. Expected renamed instructions and expected free-list
// returns go into queues. A separate monitor compares them with whatever the
// DUT presents.
// ---------------------------------------------------------------------------
module tb_reg_rename_stage;

  localparam int W = 7;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rs1, in_rs2, in_rd;
  logic         in_rd_write;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_rs1_phys, out_rs2_phys, out_rd_phys, out_old_rd_phys;
  logic         out_rd_write;
  logic         take_next_free;
  logic [W-1:0] free_reg_num;
  logic         free_list_empty;
  logic         reg_freed;
  logic [W-1:0] freed_reg_num;
  logic         commit_valid;
  logic [4:0]   commit_rd;
  logic [W-1:0] commit_rd_phys;
  logic         flush;

  always #5 clock = ~clock;

  reg_rename_stage #(.REG_FILE_ADDR_WIDTH(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_rd           (in_rd),
    .in_rd_write     (in_rd_write),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rs1_phys    (out_rs1_phys),
    .out_rs2_phys    (out_rs2_phys),
    .out_rd_phys     (out_rd_phys),
    .out_old_rd_phys (out_old_rd_phys),
    .out_rd_write    (out_rd_write),
    .take_next_free  (take_next_free),
    .free_reg_num    (free_reg_num),
    .free_list_empty (free_list_empty),
    .reg_freed       (reg_freed),
    .freed_reg_num   (freed_reg_num),
    .commit_valid    (commit_valid),
    .commit_rd       (commit_rd),
    .commit_rd_phys  (commit_rd_phys),
    .flush           (flush)
  );

  typedef struct {
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [W-1:0] rd;
    logic [W-1:0] old_rd;
    logic         wr;
  } out_item_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] num;
  } free_item_t;

  out_item_t  out_q[$];
  free_item_t free_q[$];

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;
  bit mon_en   = 0;

  // Reference model: architectural register -> physical register.
  logic [W-1:0] spec_m [32];
  logic [W-1:0] comm_m [32];
  bit           m_out_valid;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: compares what the DUT presents with the front of each queue.
  always @(negedge clock) begin
    if (mon_en) begin
      if (out_valid) begin
        if (out_q.size() == 0) begin
          chk("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          chk("out_rs1_phys",    32'(out_rs1_phys),    32'(out_q[0].rs1));
          chk("out_rs2_phys",    32'(out_rs2_phys),    32'(out_q[0].rs2));
          chk("out_rd_phys",     32'(out_rd_phys),     32'(out_q[0].rd));
          chk("out_old_rd_phys", 32'(out_old_rd_phys), 32'(out_q[0].old_rd));
          chk("out_rd_write",    32'(out_rd_write),    32'(out_q[0].wr));
          if (out_ready) begin
            $display("out: rs1=%0d rs2=%0d rd=%0d old=%0d wr=%0d",
                     out_rs1_phys, out_rs2_phys, out_rd_phys, out_old_rd_phys, out_rd_write);
            void'(out_q.pop_front());
          end else if (flush) begin
            // A stalled output is squashed by the flush.
            void'(out_q.pop_front());
          end
        end
      end
      begin
        bit due;
        due = (free_q.size() > 0) && (free_q[0].cyc == cycle_cnt);
        chk("reg_freed", 32'(reg_freed), 32'(due));
        if (due) begin
          chk("freed_reg_num", 32'(freed_reg_num), 32'(free_q[0].num));
          $display("free: phys=%0d", freed_reg_num);
          void'(free_q.pop_front());
        end
      end
    end
  end

  // Checks the combinational outputs for one cycle of the inputs currently
  // driven, records the expected results, then advances the model.
  task automatic step();
    bit na, exp_ready, acc, ce;
    out_item_t  oi;
    free_item_t fi;
    @(negedge clock);
    na        = in_rd_write && (in_rd != 5'd0);
    exp_ready = !flush && (!m_out_valid || out_ready) && (!na || !free_list_empty);
    acc       = in_valid && exp_ready;
    chk("in_ready",       32'(in_ready),       32'(exp_ready));
    chk("take_next_free", 32'(take_next_free), 32'(acc && na));
    if (acc) begin
      oi.rs1    = spec_m[in_rs1];
      oi.rs2    = spec_m[in_rs2];
      oi.rd     = na ? free_reg_num : '0;
      oi.old_rd = na ? spec_m[in_rd] : '0;
      oi.wr     = na;
      out_q.push_back(oi);
    end
    ce = commit_valid && (commit_rd != 5'd0);
    if (ce) begin
      fi.cyc = cycle_cnt + 1;
      fi.num = comm_m[commit_rd];
      free_q.push_back(fi);
      comm_m[commit_rd] = commit_rd_phys;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) spec_m[i] = comm_m[i];
    end else if (acc && na) begin
      spec_m[in_rd] = free_reg_num;
    end
    if (acc) m_out_valid = 1'b1;
    else if (out_ready || flush) m_out_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit wr,
                       input int fr, input bit emp, input bit ordy,
                       input bit cv, input int crd, input int cph, input bit fl);
    in_valid        = v;
    in_rs1          = 5'(rs1);
    in_rs2          = 5'(rs2);
    in_rd           = 5'(rd);
    in_rd_write     = wr;
    free_reg_num    = W'(fr);
    free_list_empty = emp;
    out_ready       = ordy;
    commit_valid    = cv;
    commit_rd       = 5'(crd);
    commit_rd_phys  = W'(cph);
    flush           = fl;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      spec_m[i] = W'(i);
      comm_m[i] = W'(i);
    end
    m_out_valid = 1'b0;

    // Reset must override a flush and a commit that arrive in the same cycles.
    reset = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_rd_write = 1'b1;
    free_reg_num = W'(90); free_list_empty = 1'b0; out_ready = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_rd_phys = W'(99); flush = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b0; in_rd_write = 1'b0; commit_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("reset_out_valid",       32'(out_valid),       32'd0);
    chk("reset_out_rs1_phys",    32'(out_rs1_phys),    32'd0);
    chk("reset_out_rs2_phys",    32'(out_rs2_phys),    32'd0);
    chk("reset_out_rd_phys",     32'(out_rd_phys),     32'd0);
    chk("reset_out_old_rd_phys", 32'(out_old_rd_phys), 32'd0);
    chk("reset_out_rd_write",    32'(out_rd_write),    32'd0);
    chk("reset_reg_freed",       32'(reg_freed),       32'd0);
    chk("reset_freed_reg_num",   32'(freed_reg_num),   32'd0);
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    //     v rs1 rs2 rd wr  free emp ordy cv crd cph fl
    drive(1, 3,  4,  5, 1,  32, 0,  1,   0, 0,  0,  0);   // rd 5 -> 32
    drive(1, 5,  0,  0, 0,   0, 0,  1,   0, 0,  0,  0);   // rs1 5 reads 32
    drive(1, 7,  0,  7, 1,  40, 0,  1,   0, 0,  0,  0);   // rs1 == rd sees old 7
    drive(1, 0,  0,  0, 1,  41, 0,  1,   0, 0,  0,  0);   // rd x0: no allocation
    drive(1, 1,  2,  9, 1,  45, 1,  1,   0, 0,  0,  0);   // free list empty: stall
    drive(1, 1,  2,  9, 1,  45, 1,  1,   0, 0,  0,  0);
    drive(1, 1,  2,  9, 1,  50, 0,  1,   0, 0,  0,  0);   // rd 9 -> 50
    drive(1, 9,  7, 10, 1,  51, 0,  0,   0, 0,  0,  0);   // downstream stall
    drive(1, 9,  7, 10, 1,  51, 0,  0,   0, 0,  0,  0);
    drive(1, 9,  7, 10, 1,  51, 0,  0,   0, 0,  0,  0);
    drive(1, 9,  7, 10, 1,  51, 0,  1,   0, 0,  0,  0);   // rd 10 -> 51
    drive(0, 0,  0,  0, 0,   0, 0,  1,   1, 5, 32,  0);   // frees 5
    drive(0, 0,  0,  0, 0,   0, 0,  1,   1, 5, 33,  0);   // frees 32
    drive(0, 0,  0,  0, 0,   0, 0,  1,   1, 0,  3,  0);   // x0: nothing freed
    drive(1, 0,  0,  6, 1,  60, 0,  1,   0, 0,  0,  0);   // rd 6 -> 60
    drive(0, 0,  0,  0, 0,   0, 0,  1,   1, 6, 60,  0);
    drive(1, 0,  0,  6, 1,  61, 0,  1,   0, 0,  0,  0);   // rd 6 -> 61
    drive(1, 6,  0,  6, 1,  62, 0,  1,   1, 8, 70,  1);   // flush with commit
    drive(1, 6,  0,  0, 0,   0, 0,  1,   0, 0,  0,  0);   // x6 -> 60
    drive(1, 8,  0,  0, 0,   0, 0,  1,   0, 0,  0,  0);   // x8 -> 70
    drive(0, 0,  0,  0, 0,   0, 0,  1,   0, 0,  0,  0);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
            int'($urandom_range(32, 127)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 127)), $urandom_range(0, 19) == 0);
    end

    // Drain the output register and any pending free pulse.
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("out_queue_drained",  32'(out_q.size()),  32'd0);
    chk("free_queue_drained", 32'(free_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
